// File: rtl/pc_nested_int_if.sv
// Bundle of the sequencer/decoder-facing signals of the program counter.
// Latency: none (wires only).
// Backpressure: none; strobes are qualified inside the program counter.
// PC_INT_MASK_EN adds MASK_LD/MASK_DIN.
interface pc_nested_int_if #(
  parameter int AW      = 16,
  parameter int NUM_INT = 4,
  parameter int NUM_BKP = 2
);
  localparam int LW  = $clog2(NUM_INT + 1);
  localparam int BSW = (NUM_BKP > 1) ? $clog2(NUM_BKP) : 1;

  logic               FETCH;
  logic               COMMIT;
  logic               PC_ENX;
  logic [1:0]         PC_BASEX;
  logic [1:0]         PC_OFFSETX;
  logic [AW-1:0]      REGB_DOUT;
  logic [AW-1:0]      DIN;
  logic [NUM_INT-1:0] INT_REQ;
  logic               INT_TAKE;
  logic               RETI;
  logic               ERR_CLR;
  logic               BKP_LD;
  logic [BSW-1:0]     BKP_SEL;
  logic [AW-1:0]      BKP_ADDR_IN;
  logic               BKP_EN_IN;
`ifdef PC_INT_MASK_EN
  logic               MASK_LD;
  logic [NUM_INT-1:0] MASK_DIN;
`endif
  logic [NUM_INT-1:0] INT_ACK;
  logic [LW-1:0]      INT_LEVEL;
  logic               STACK_FULL;
  logic               STACK_OVF;
  logic               STACK_UNF;
  logic [NUM_BKP-1:0] DEBUG_BKP_HIT;
  logic               DEBUG_AT_BKP;
  logic [AW-1:0]      PC_A_NEXT;
  logic [AW-1:0]      PC_A;
  logic [AW-1:0]      HERE;

  modport master (
    output FETCH, COMMIT, PC_ENX, PC_BASEX, PC_OFFSETX, REGB_DOUT, DIN,
    output INT_REQ, INT_TAKE, RETI, ERR_CLR,
    output BKP_LD, BKP_SEL, BKP_ADDR_IN, BKP_EN_IN,
`ifdef PC_INT_MASK_EN
    output MASK_LD, MASK_DIN,
`endif
    input  INT_ACK, INT_LEVEL, STACK_FULL, STACK_OVF, STACK_UNF,
    input  DEBUG_BKP_HIT, DEBUG_AT_BKP, PC_A_NEXT, PC_A, HERE
  );

  modport slave (
    input  FETCH, COMMIT, PC_ENX, PC_BASEX, PC_OFFSETX, REGB_DOUT, DIN,
    input  INT_REQ, INT_TAKE, RETI, ERR_CLR,
    input  BKP_LD, BKP_SEL, BKP_ADDR_IN, BKP_EN_IN,
`ifdef PC_INT_MASK_EN
    input  MASK_LD, MASK_DIN,
`endif
    output INT_ACK, INT_LEVEL, STACK_FULL, STACK_OVF, STACK_UNF,
    output DEBUG_BKP_HIT, DEBUG_AT_BKP, PC_A_NEXT, PC_A, HERE
  );
endinterface

// File: rtl/pc_nested_int.sv
// Forth CPU program counter with prioritised nested interrupts and breakpoints.
// Latency: PC_A_NEXT combinational; PC_A/HERE/stack/level update one edge after FETCH & PC_ENX.
// Backpressure: none; PC_ENX stalls all PC/stack state. Optional macro PC_INT_MASK_EN adds INT_MASK.
module pc_nested_int #(
  parameter int AW          = 16,
  parameter int NUM_INT     = 4,
  parameter int STACK_DEPTH = 4,
  parameter int NUM_BKP     = 2,
  parameter int INTV_BASE   = 4,
  parameter int INTV_STRIDE = 4
) (
  input logic           CLK,
  input logic           RESET,
  pc_nested_int_if.slave bus
);
  localparam int LW  = $clog2(NUM_INT + 1);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [AW-1:0] PC_RST = {{(AW-1){1'b1}}, 1'b0};

  logic [AW-1:0]      pc_a, here, arga, argb, sum, vec_addr, pc_next;
  logic [LW-1:0]      int_level, elig_idx;
  logic               elig, full, empty, ent, ret, upd;
  logic [SPW-1:0]     sp;
  logic [AIW-1:0]     top_idx, push_idx;
  logic [AW-1:0]      stk_addr [STACK_DEPTH];
  logic [LW-1:0]      stk_lvl  [STACK_DEPTH];
  logic [NUM_INT-1:0] int_ack, int_mask;
  logic               ovf, unf;
  logic [AW-1:0]      bkp_addr [NUM_BKP];
  logic [NUM_BKP-1:0] bkp_act, bkp_hit;

`ifdef PC_INT_MASK_EN
  // Per-source enable register; all sources enabled out of reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)            int_mask <= '1;
    else if (bus.MASK_LD) int_mask <= bus.MASK_DIN;
  end
`else
  assign int_mask = '1;
`endif

  assign upd      = bus.FETCH & bus.PC_ENX;
  assign full     = (sp == SPW'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign top_idx  = AIW'(sp - 1'b1);
  assign push_idx = AIW'(sp);

  // Adder operands and sum; wraps silently at 2^AW.
  always_comb begin
    arga = pc_a;
    unique case (bus.PC_BASEX)
      2'd1:    arga = bus.REGB_DOUT;
      2'd2:    arga = '0;
      default: arga = pc_a;
    endcase
    argb = '0;
    unique case (bus.PC_OFFSETX)
      2'd1:    argb = AW'(2);
      2'd2:    argb = AW'(4);
      2'd3:    argb = bus.DIN;
      default: argb = '0;
    endcase
    sum = arga + argb;
  end

  // Lowest-index enabled request that outranks the level currently in service.
  always_comb begin
    elig     = 1'b0;
    elig_idx = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (bus.INT_REQ[i] && int_mask[i] && (LW'(i) < int_level)) begin
        elig     = 1'b1;
        elig_idx = LW'(i);
      end
    end
  end

  // Entry beats return; vector address, popped address, or the adder result.
  always_comb begin
    ent      = bus.INT_TAKE & elig & ~full;
    ret      = bus.RETI & ~empty & ~ent;
    vec_addr = AW'(INTV_BASE) + AW'(elig_idx) * AW'(INTV_STRIDE);
    pc_next  = sum;
    if (ent)      pc_next = vec_addr;
    else if (ret) pc_next = stk_addr[top_idx];
  end

  // PC and HERE registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_a <= PC_RST;
      here <= '0;
    end else if (upd) begin
      pc_a <= pc_next;
      here <= pc_next + AW'(2);
    end
  end

  // Return stack, in-service level and the single-cycle acknowledge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sp        <= '0;
      int_level <= LW'(NUM_INT);
      int_ack   <= '0;
      for (int d = 0; d < STACK_DEPTH; d++) begin
        stk_addr[d] <= '0;
        stk_lvl[d]  <= '0;
      end
    end else begin
      int_ack <= '0;
      if (upd && ent) begin
        stk_addr[push_idx] <= sum;
        stk_lvl[push_idx]  <= int_level;
        sp                 <= sp + 1'b1;
        int_level          <= elig_idx;
        int_ack            <= NUM_INT'(1) << elig_idx;
      end else if (upd && ret) begin
        sp        <= sp - 1'b1;
        int_level <= stk_lvl[top_idx];
      end
    end
  end

  // Sticky stack errors; a new error in the clearing cycle takes precedence.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (upd && bus.INT_TAKE && elig && full) ovf <= 1'b1;
      else if (bus.ERR_CLR)                    ovf <= 1'b0;
      if (upd && bus.RETI && empty && !ent)    unf <= 1'b1;
      else if (bus.ERR_CLR)                    unf <= 1'b0;
    end
  end

  // Breakpoint slots and per-slot hit flags sampled on COMMIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bkp_act <= '0;
      bkp_hit <= '0;
      for (int k = 0; k < NUM_BKP; k++) bkp_addr[k] <= '0;
    end else begin
      if (bus.COMMIT) begin
        for (int k = 0; k < NUM_BKP; k++)
          bkp_hit[k] <= bkp_act[k] && (pc_next == bkp_addr[k]);
      end
      if (bus.BKP_LD) begin
        bkp_addr[bus.BKP_SEL] <= bus.BKP_ADDR_IN;
        bkp_act[bus.BKP_SEL]  <= bus.BKP_EN_IN;
      end
    end
  end

  assign bus.PC_A          = pc_a;
  assign bus.HERE          = here;
  assign bus.PC_A_NEXT     = pc_next;
  assign bus.INT_ACK       = int_ack;
  assign bus.INT_LEVEL     = int_level;
  assign bus.STACK_FULL    = full;
  assign bus.STACK_OVF     = ovf;
  assign bus.STACK_UNF     = unf;
  assign bus.DEBUG_BKP_HIT = bkp_hit;
  assign bus.DEBUG_AT_BKP  = |bkp_hit;
endmodule

// File: tb/tb_pc_nested_int.sv
// Self-checking bench for pc_nested_int: directed scenarios plus random traffic
// against a queue-based reference model; all outputs compared every cycle.
// Build with PC_INT_MASK_EN defined to exercise the interrupt mask as well.
module tb_pc_nested_int;
  localparam int AW = 16, NI = 4, SD = 3, NB = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  pc_nested_int_if #(.AW(AW), .NUM_INT(NI), .NUM_BKP(NB)) bus ();
  pc_nested_int #(.AW(AW), .NUM_INT(NI), .STACK_DEPTH(SD), .NUM_BKP(NB),
                  .INTV_BASE(4), .INTV_STRIDE(4))
    dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int n_tot = 0, n_pass = 0;
  bit started = 0;

  // reference state
  int m_pc, m_here, m_lvl, m_ack, m_hit, m_mask;
  int m_sa[$];
  int m_sl[$];
  bit m_ovf, m_unf;
  int m_ba[NB];
  bit m_be[NB];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int f_idx();
    for (int i = 0; i < NI; i++)
      if (bus.INT_REQ[i] && m_mask[i] && i < m_lvl) return i;
    return -1;
  endfunction

  function automatic int f_sum();
    int a, b;
    case (bus.PC_BASEX)
      2'd1: a = int'(bus.REGB_DOUT);
      2'd2: a = 0;
      default: a = m_pc;
    endcase
    case (bus.PC_OFFSETX)
      2'd0: b = 0;
      2'd1: b = 2;
      2'd2: b = 4;
      default: b = int'(bus.DIN);
    endcase
    return (a + b) % 65536;
  endfunction

  function automatic int f_next();
    int idx = f_idx();
    if (bus.INT_TAKE && idx >= 0 && m_sa.size() < SD) return 4 + 4 * idx;
    if (bus.RETI && m_sa.size() > 0) return m_sa[$];
    return f_sum();
  endfunction

  // Reference model: advances on each clock edge, resets on RESET.
  initial forever begin
    int idx, nxt, s;
    bit ent, ret, full, emp, upd;
    @(posedge CLK or posedge RESET);
    if (RESET) begin
      m_pc = 16'hFFFE; m_here = 0; m_lvl = NI; m_ack = 0; m_hit = 0;
      m_ovf = 0; m_unf = 0; m_mask = 'hF;
      m_sa.delete(); m_sl.delete();
      for (int k = 0; k < NB; k++) begin m_ba[k] = 0; m_be[k] = 0; end
    end else begin
      idx  = f_idx();
      full = (m_sa.size() == SD);
      emp  = (m_sa.size() == 0);
      ent  = bus.INT_TAKE && idx >= 0 && !full;
      ret  = bus.RETI && !emp && !ent;
      nxt  = f_next();
      s    = f_sum();
      upd  = bus.FETCH && bus.PC_ENX;
      if (bus.COMMIT) begin
        m_hit = 0;
        for (int k = 0; k < NB; k++) if (m_be[k] && nxt == m_ba[k]) m_hit += (1 << k);
      end
      m_ack = 0;
      if (upd) begin
        m_pc = nxt;
        m_here = (nxt + 2) % 65536;
        if (ent) begin
          m_sa.push_back(s); m_sl.push_back(m_lvl);
          m_lvl = idx; m_ack = 1 << idx;
        end else if (ret) begin
          void'(m_sa.pop_back());
          m_lvl = m_sl.pop_back();
        end
      end
      if (upd && bus.INT_TAKE && idx >= 0 && full) m_ovf = 1;
      else if (bus.ERR_CLR) m_ovf = 0;
      if (upd && bus.RETI && emp && !ent) m_unf = 1;
      else if (bus.ERR_CLR) m_unf = 0;
      if (bus.BKP_LD) begin
        m_ba[bus.BKP_SEL] = int'(bus.BKP_ADDR_IN);
        m_be[bus.BKP_SEL] = bus.BKP_EN_IN;
      end
`ifdef PC_INT_MASK_EN
      if (bus.MASK_LD) m_mask = int'(bus.MASK_DIN);
`endif
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge CLK);
    #2;
    if (started) begin
      chk("pc_a", bus.PC_A, m_pc);
      chk("here", bus.HERE, m_here);
      chk("pc_a_next", bus.PC_A_NEXT, f_next());
      chk("int_level", bus.INT_LEVEL, m_lvl);
      chk("int_ack", bus.INT_ACK, m_ack);
      chk("stack_full", bus.STACK_FULL, m_sa.size() == SD);
      chk("stack_ovf", bus.STACK_OVF, m_ovf);
      chk("stack_unf", bus.STACK_UNF, m_unf);
      chk("bkp_hit", bus.DEBUG_BKP_HIT, m_hit);
      chk("at_bkp", bus.DEBUG_AT_BKP, m_hit != 0);
    end
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic drv(input logic [1:0] b, input logic [1:0] o, input logic [15:0] d,
                     input logic [3:0] r, input logic t, input logic ri);
    bus.FETCH = 1; bus.PC_ENX = 1; bus.PC_BASEX = b; bus.PC_OFFSETX = o;
    bus.DIN = d; bus.INT_REQ = r; bus.INT_TAKE = t; bus.RETI = ri;
    cyc();
  endtask

  initial begin
    bus.FETCH = 0; bus.COMMIT = 0; bus.PC_ENX = 0; bus.PC_BASEX = 0; bus.PC_OFFSETX = 0;
    bus.REGB_DOUT = 0; bus.DIN = 0; bus.INT_REQ = 0; bus.INT_TAKE = 0; bus.RETI = 0;
    bus.ERR_CLR = 0; bus.BKP_LD = 0; bus.BKP_SEL = 0; bus.BKP_ADDR_IN = 0; bus.BKP_EN_IN = 0;
`ifdef PC_INT_MASK_EN
    bus.MASK_LD = 0; bus.MASK_DIN = 0;
`endif
    #1 RESET = 1;
    @(negedge CLK);
    started = 1;
    #1;
    chk("rst_pc", bus.PC_A, 16'hFFFE);
    chk("rst_here", bus.HERE, 0);
    chk("rst_level", bus.INT_LEVEL, 4);
    chk("rst_err", {bus.STACK_OVF, bus.STACK_UNF, bus.STACK_FULL}, 0);
    RESET = 0;

    // sequential fetch with wrap from 0xFFFE
    drv(0, 1, 0, 0, 0, 0);
    chk("seq_pc0", bus.PC_A, 16'h0000); chk("seq_here0", bus.HERE, 16'h0002);
    drv(0, 1, 0, 0, 0, 0);
    chk("seq_pc1", bus.PC_A, 16'h0002); chk("seq_here1", bus.HERE, 16'h0004);
    drv(2, 3, 16'h0100, 0, 0, 0);
    chk("jump_pc", bus.PC_A, 16'h0100);

    // nested entry and return
    drv(0, 1, 0, 4'b0100, 1, 0);
    chk("ent2_pc", bus.PC_A, 16'h000C); chk("ent2_lvl", bus.INT_LEVEL, 2);
    chk("ent2_ack", bus.INT_ACK, 4'b0100);
    drv(0, 1, 0, 4'b0001, 1, 0);
    chk("ent0_pc", bus.PC_A, 16'h0004); chk("ent0_lvl", bus.INT_LEVEL, 0);
    chk("ent0_ack", bus.INT_ACK, 4'b0001);
    drv(0, 1, 0, 0, 0, 1);
    chk("ret0_pc", bus.PC_A, 16'h000E); chk("ret0_lvl", bus.INT_LEVEL, 2);
    chk("ret0_ack", bus.INT_ACK, 0);
    drv(0, 1, 0, 4'b1000, 1, 0);
    chk("low_pc", bus.PC_A, 16'h0010); chk("low_lvl", bus.INT_LEVEL, 2);
    drv(0, 1, 0, 0, 0, 1);
    chk("ret2_pc", bus.PC_A, 16'h0102); chk("ret2_lvl", bus.INT_LEVEL, 4);

    // fill the stack, then overflow and underflow
    drv(0, 1, 0, 4'b1000, 1, 0);
    drv(0, 1, 0, 4'b0100, 1, 0);
    drv(0, 1, 0, 4'b0010, 1, 0);
    chk("full_pc", bus.PC_A, 16'h0008); chk("full_flag", bus.STACK_FULL, 1);
    drv(0, 1, 0, 4'b0001, 1, 0);
    chk("ovf_pc", bus.PC_A, 16'h000A); chk("ovf_flag", bus.STACK_OVF, 1);
    chk("ovf_ack", bus.INT_ACK, 0); chk("ovf_lvl", bus.INT_LEVEL, 1);
    drv(0, 1, 0, 0, 0, 1); chk("pop1_pc", bus.PC_A, 16'h000E);
    drv(0, 1, 0, 0, 0, 1); chk("pop2_pc", bus.PC_A, 16'h0012);
    drv(0, 1, 0, 0, 0, 1); chk("pop3_pc", bus.PC_A, 16'h0104);
    chk("pop3_lvl", bus.INT_LEVEL, 4);
    drv(0, 1, 0, 0, 0, 1);
    chk("unf_pc", bus.PC_A, 16'h0106); chk("unf_flag", bus.STACK_UNF, 1);
    bus.ERR_CLR = 1;
    drv(0, 1, 0, 0, 0, 1);
    chk("clr_setwins", bus.STACK_UNF, 1); chk("clr_ovf", bus.STACK_OVF, 0);
    bus.FETCH = 0; bus.RETI = 0;
    cyc();
    chk("clr_unf", bus.STACK_UNF, 0); chk("clr_hold_pc", bus.PC_A, 16'h0108);
    bus.ERR_CLR = 0;

    // breakpoint slot 1
    bus.BKP_LD = 1; bus.BKP_SEL = 1; bus.BKP_ADDR_IN = 16'h0040; bus.BKP_EN_IN = 1;
    cyc();
    bus.BKP_LD = 0; bus.PC_BASEX = 2; bus.PC_OFFSETX = 3; bus.DIN = 16'h0040; bus.COMMIT = 1;
    cyc();
    chk("bkp_hit", bus.DEBUG_BKP_HIT, 2'b10); chk("bkp_at", bus.DEBUG_AT_BKP, 1);
    bus.DIN = 16'h0042;
    cyc();
    chk("bkp_miss", bus.DEBUG_BKP_HIT, 0); chk("bkp_at0", bus.DEBUG_AT_BKP, 0);
    bus.COMMIT = 0;

`ifdef PC_INT_MASK_EN
    bus.MASK_LD = 1; bus.MASK_DIN = 4'b1110;
    cyc();
    bus.MASK_LD = 0;
    drv(2, 3, 16'h0200, 4'b0001, 1, 0);
    chk("mask_pc", bus.PC_A, 16'h0200); chk("mask_ack", bus.INT_ACK, 0);
    chk("mask_ovf", bus.STACK_OVF, 0);
`endif

    // asynchronous reset mid-operation
    drv(2, 3, 16'h1234, 0, 0, 0);
    #2 RESET = 1;
    #1 chk("async_pc", bus.PC_A, 16'hFFFE);
    chk("async_lvl", bus.INT_LEVEL, 4);
    RESET = 0;
    cyc();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.FETCH      = ($urandom_range(0, 9) < 7);
      bus.PC_ENX     = ($urandom_range(0, 9) < 8);
      bus.COMMIT     = $urandom_range(0, 1);
      bus.PC_BASEX   = 2'($urandom_range(0, 3));
      bus.PC_OFFSETX = 2'($urandom_range(0, 3));
      bus.REGB_DOUT  = 16'($urandom);
      bus.DIN        = ($urandom_range(0, 3) == 0) ? 16'h0040 : 16'($urandom_range(0, 255));
      bus.INT_REQ    = 4'($urandom);
      bus.INT_TAKE   = $urandom_range(0, 1);
      bus.RETI       = ($urandom_range(0, 9) < 3);
      bus.ERR_CLR    = ($urandom_range(0, 9) == 0);
      bus.BKP_LD     = ($urandom_range(0, 9) == 0);
      bus.BKP_SEL    = 1'($urandom_range(0, 1));
      bus.BKP_ADDR_IN = ($urandom_range(0, 1) == 1) ? 16'h0040 : 16'(4 * $urandom_range(1, 4));
      bus.BKP_EN_IN  = ($urandom_range(0, 3) != 0);
`ifdef PC_INT_MASK_EN
      bus.MASK_LD    = ($urandom_range(0, 19) == 0);
      bus.MASK_DIN   = 4'($urandom);
`endif
      if ($urandom_range(0, 299) == 0) begin
        #2 RESET = 1;
        #1 RESET = 0;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pc_nested_int.md
Name: pc_nested_int

Overview:
- Parametrised next-generation program counter for the Forth CPU.
- Computes the next fetch address from base/offset muxes and an adder.
- Supports NUM_INT prioritised interrupt vectors with nesting via a return-address/priority stack, and NUM_BKP breakpoint comparators.
- Sits between the instruction decoder/sequencer and the memory address bus; drives PC_A, PC_A_NEXT and HERE.

Parameters:
AW, 16, address/data width in bits
NUM_INT, 4, interrupt sources; index 0 = highest priority
STACK_DEPTH, 4, maximum nesting depth of the return stack
NUM_BKP, 2, number of breakpoint comparators
INTV_BASE, 4, address of vector 0
INTV_STRIDE, 4, byte spacing between vectors

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-high reset
FETCH  in  1  fetch phase strobe
COMMIT  in  1  commit phase strobe
PC_ENX  in  1  PC update enable (qualified by FETCH)
PC_BASEX  in  2  adder base: 0=PC_A, 1=REGB_DOUT, 2=zero, 3=PC_A
PC_OFFSETX  in  2  adder offset: 0=0, 1=2, 2=4, 3=DIN
REGB_DOUT  in  AW  register-file B operand
DIN  in  AW  immediate/memory operand
INT_REQ  in  NUM_INT  level interrupt requests
INT_TAKE  in  1  sequencer permits interrupt entry this fetch
RETI  in  1  return-from-interrupt request
ERR_CLR  in  1  clears sticky error flags
BKP_LD  in  1  load breakpoint slot
BKP_SEL  in  clog2(NUM_BKP)  slot index for BKP_LD
BKP_ADDR_IN  in  AW  breakpoint address
BKP_EN_IN  in  1  breakpoint slot active flag
INT_ACK  out  NUM_INT  one-cycle acknowledge of the vector taken
INT_LEVEL  out  clog2(NUM_INT+1)  current in-service priority; NUM_INT = none
STACK_FULL  out  1  stack holds STACK_DEPTH entries
STACK_OVF  out  1  sticky: entry attempted while full
STACK_UNF  out  1  sticky: RETI while empty
DEBUG_BKP_HIT  out  NUM_BKP  per-slot registered hit
DEBUG_AT_BKP  out  1  OR of DEBUG_BKP_HIT
PC_A_NEXT  out  AW  combinational next address
PC_A  out  AW  current PC
HERE  out  AW  PC_A + 2 register

Behaviour:
- SUM = ARGA + ARGB, modulo 2^AW (wraps without a flag).
- Eligible interrupt: lowest index i with INT_REQ[i] set and i < INT_LEVEL.
- Entry condition ENT = INT_TAKE & eligible & !STACK_FULL.
- Return condition RET = RETI & stack non-empty & !ENT; entry wins when both are requested in the same cycle.
- PC_A_NEXT priority: ENT -> INTV_BASE + i*INTV_STRIDE; else RET -> top-of-stack address; else SUM.
- On FETCH & PC_ENX:
  - PC_A <= PC_A_NEXT; HERE <= PC_A_NEXT + 2.
  - ENT: push {SUM, INT_LEVEL}; INT_LEVEL <= i; INT_ACK[i] = 1 for exactly the next cycle.
  - RET: pop; PC_A gets the popped address; INT_LEVEL <= popped level.
- Stack/level updates and INT_ACK occur only on FETCH & PC_ENX. No change otherwise.
- Boundary errors (set only on FETCH & PC_ENX; PC_A follows SUM in both cases):
  - INT_TAKE & eligible & STACK_FULL -> STACK_OVF <= 1, no push.
  - RETI & empty & !ENT -> STACK_UNF <= 1.
- ERR_CLR clears STACK_OVF and STACK_UNF; a set in the same cycle wins.
- Breakpoints:
  - BKP_LD writes slot BKP_SEL (address and active flag) at the clock edge.
  - On COMMIT, DEBUG_BKP_HIT[k] <= active[k] & (PC_A_NEXT == addr[k]); otherwise the value holds.
  - DEBUG_AT_BKP is combinational OR of DEBUG_BKP_HIT.
- RESET values (asynchronous, mid-operation included):
  - PC_A = 2^AW-2; HERE = 0; stack empty; INT_LEVEL = NUM_INT.
  - INT_ACK = 0; STACK_OVF = STACK_UNF = 0.
  - All breakpoint slots inactive with address 0; DEBUG_BKP_HIT = 0.

Optional Feature:
- Macro: PC_INT_MASK_EN.
- Defined:
  - Adds inputs MASK_LD (1) and MASK_DIN (NUM_INT), and an INT_MASK register, reset value all-ones, loaded on MASK_LD.
  - Eligibility additionally requires INT_MASK[i] = 1.
  - Masked requests never set STACK_OVF.
- Undefined: ports absent; all sources are always enabled.

Test Plan:
- Reset release, PC_ENX & FETCH, base=PC_A, offset=2 -> PC_A 0xFFFE->0x0000->0x0002, HERE = 0x0002, 0x0004.
- PC_A=0x0100, INT_REQ=4'b0100, INT_TAKE on fetch -> PC_A=0x000C, INT_ACK[2] one cycle, INT_LEVEL=2, stack holds 0x0102.
- In level 2, assert INT_REQ[0] and INT_TAKE -> PC_A=0x0004, INT_LEVEL=0; RETI -> 0x000E/level 2; RETI -> 0x0102/level 4; INT_REQ[3] while level 2 -> ignored.
- Nest 4 deep, then INT_TAKE with INT_REQ[0] eligible -> STACK_OVF=1, PC_A=SUM; RETI on empty stack -> STACK_UNF=1; ERR_CLR -> both 0.
- Slot 1 loaded with 0x0040 active, COMMIT with PC_A_NEXT=0x0040 -> DEBUG_BKP_HIT=2'b10, DEBUG_AT_BKP=1; next COMMIT at 0x0042 -> 0.
- PC_INT_MASK_EN defined, MASK_DIN=4'b1110 -> INT_REQ[0] with INT_TAKE not taken, PC_A=SUM, no INT_ACK.
